sprite_cmd_scheduler: RTL

//  Sits between the Avalon host slave and all sprite display sub-components (shared 32-bit command bus).

---
 rtl/sprite_cmd_pkg.sv | 23 ++
 rtl/sprite_cmd_scheduler_if.sv | 23 ++
 rtl/cmd_fifo.sv | 45 ++++
 rtl/sprite_cmd_scheduler.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the sprite command scheduler: command word layout,
// info codes that the scheduler acts on, and scheduler FSM state encodings.
package sprite_cmd_pkg;

  localparam logic [3:0] INFO_WRITE = 4'b0001;
  localparam logic [3:0] INFO_FLUSH = 4'b1111;

  localparam int INFO_LSB = 17;

  typedef struct packed {
    logic [5:0]  sub_comp;
    logic [4:0]  child;
    logic [3:0]  info;
    logic [2:0]  typ;
    logic        pp;
    logic [12:0] msg;
  } cmd_t;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_WAIT_VB = 2'd1;
  localparam logic [1:0] ST_SWAP    = 2'd2;

endpackage

// File: rtl/sprite_cmd_scheduler_if.sv
// Host-side Avalon slave signals, video line count and the sprite command broadcast.
interface sprite_cmd_scheduler_if;

  logic        avs_write;
  logic        avs_read;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;
  logic        swap_irq;

  modport master (
    output avs_write, avs_read, avs_writedata, vcount,
    input  avs_waitrequest, avs_readdata, cmd_out, swap_irq
  );

  modport slave (
    input  avs_write, avs_read, avs_writedata, vcount,
    output avs_waitrequest, avs_readdata, cmd_out, swap_irq
  );

endinterface

// File: rtl/cmd_fifo.sv
// Show-ahead FIFO: head is valid whenever !empty; push is ignored when full, pop when empty.
// Pointers carry one extra wrap bit so full/empty come from a plain MSB compare.
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/sprite_cmd_scheduler.sv
// Queues host sprite commands and broadcasts them one per cycle (2 cycles after acceptance),
// steering pp to the back buffer; commits swap buffers only in vblank, once per frame. Host waits while the queue is full.
module sprite_cmd_scheduler #(
  parameter int DEPTH    = 16,
  parameter int V_ACTIVE = 480
) (
  input logic                   clk,
  input logic                   reset,
  sprite_cmd_scheduler_if.slave bus
);

  import sprite_cmd_pkg::*;

  localparam logic [9:0] VB_LINE = 10'(V_ACTIVE);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        front;
  logic        swapped;
  logic [15:0] frame_cnt;
  logic        in_vblank;
  logic        commit_pending;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_head;
  logic [3:0]  wr_info;
  cmd_t        head;

  cmd_t        stage_dat;
  cmd_t        stage_nxt;
  logic        stage_irq;
  logic        stage_irq_nxt;
  logic [31:0] cmd_q;
  logic        irq_q;
  logic [31:0] rdata_q;

  assign wr_info        = bus.avs_writedata[INFO_LSB +: 4];
  assign fifo_push      = bus.avs_write && !fifo_full &&
                          (wr_info == INFO_WRITE || wr_info == INFO_FLUSH);
  assign head           = cmd_t'(fifo_head);
  assign in_vblank      = (bus.vcount >= VB_LINE);
  assign commit_pending = (state == ST_WAIT_VB) || (state == ST_SWAP);

  assign bus.avs_waitrequest = fifo_full;
  assign bus.cmd_out         = cmd_q;
  assign bus.swap_irq        = irq_q;
  assign bus.avs_readdata    = rdata_q;

  cmd_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (bus.avs_writedata),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // The queue only ever holds WRITE and FLUSH words, so a non-FLUSH head is a WRITE.
  always_comb begin
    state_nxt     = state;
    fifo_pop      = 1'b0;
    stage_nxt     = '0;
    stage_irq_nxt = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (!fifo_empty) begin
          if (head.info == INFO_FLUSH) begin
            state_nxt = ST_WAIT_VB;
          end else begin
            fifo_pop     = 1'b1;
            stage_nxt    = head;
            stage_nxt.pp = ~front;
          end
        end
      end
      ST_WAIT_VB: begin
        if (in_vblank && !swapped) state_nxt = ST_SWAP;
      end
      ST_SWAP: begin
        fifo_pop       = 1'b1;
        stage_nxt.info = INFO_FLUSH;
        stage_nxt.pp   = ~front;
        stage_irq_nxt  = 1'b1;
        state_nxt      = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      front     <= 1'b0;
      swapped   <= 1'b0;
      frame_cnt <= '0;
      stage_dat <= '0;
      stage_irq <= 1'b0;
      cmd_q     <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state     <= state_nxt;
      stage_dat <= stage_nxt;
      stage_irq <= stage_irq_nxt;
      cmd_q     <= stage_dat;
      irq_q     <= stage_irq;
      if (state == ST_SWAP) begin
        front     <= ~front;
        frame_cnt <= frame_cnt + 16'd1;
        swapped   <= 1'b1;
      end else if (!in_vblank) begin
        swapped   <= 1'b0;
      end
      if (bus.avs_read) begin
        rdata_q <= {commit_pending, fifo_empty, front, 13'b0, frame_cnt};
      end
    end
  end

endmodule
